// File: rtl/up_down_counter_mod.sv
// Parametrised loadable up/down counter with runtime modulus, programmable step,
// wrap/saturate selection, registered terminal-count pulse and sticky over/underflow flags.
module up_down_counter_mod #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ld,
  input  logic              clr,
  input  logic              mode,
  input  logic              sat,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  d_in,
  input  logic              flag_clr,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf,
  output logic              udf
);

  typedef logic [WIDTH:0] ext_t;

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             hit;
  } step_res_t;

  localparam ext_t ONE = ext_t'(1);

  // Up step: exact landing on the limit counts as a boundary hit, crossing it wraps or clamps.
  function automatic step_res_t f_step_up(input ext_t cnt, input ext_t stp,
                                          input ext_t lim, input logic sat_i);
    step_res_t res;
    ext_t      sum;
    sum = cnt + stp;
    if (sum <= lim) begin
      res.cnt = WIDTH'(sum);
      res.hit = (sum == lim);
    end else begin
      res.cnt = sat_i ? WIDTH'(lim) : WIDTH'(sum - lim - ONE);
      res.hit = 1'b1;
    end
    return res;
  endfunction

  function automatic step_res_t f_step_down(input ext_t cnt, input ext_t stp,
                                            input ext_t lim, input logic sat_i);
    step_res_t res;
    if (cnt >= stp) begin
      res.cnt = WIDTH'(cnt - stp);
      res.hit = (cnt == stp);
    end else begin
      res.cnt = sat_i ? '0 : WIDTH'(cnt + lim + ONE - stp);
      res.hit = 1'b1;
    end
    return res;
  endfunction

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;
  logic             r_udf;

  ext_t             w_cnt_x;
  ext_t             w_step_x;
  ext_t             w_lim_x;
  step_res_t        w_up;
  step_res_t        w_dn;
  logic             w_step_ok;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_tc_nxt;
  logic             w_set_ovf;
  logic             w_set_udf;

  assign w_cnt_x   = {1'b0, r_count};
  assign w_step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign w_lim_x   = {1'b0, limit};
  assign w_up      = f_step_up(w_cnt_x, w_step_x, w_lim_x, sat);
  assign w_dn      = f_step_down(w_cnt_x, w_step_x, w_lim_x, sat);
  // A zero step or a step wider than the whole range is a no-op, never a corruption.
  assign w_step_ok = (w_step_x != '0) && (w_step_x <= w_lim_x);

  always_comb begin
    w_cnt_nxt = r_count;
    w_tc_nxt  = 1'b0;
    w_set_ovf = 1'b0;
    w_set_udf = 1'b0;
    if (ld) begin
      w_cnt_nxt = (d_in > limit) ? limit : d_in;
    end else if (clr) begin
      w_cnt_nxt = '0;
    end else if (en && w_step_ok) begin
      if (w_cnt_x > w_lim_x) begin
        // Limit was lowered below the current count: re-enter the legal range at a bound.
        w_cnt_nxt = (mode && !sat) ? '0 : limit;
        w_tc_nxt  = 1'b1;
        w_set_ovf = mode;
        w_set_udf = !mode;
      end else if (mode) begin
        w_cnt_nxt = w_up.cnt;
        w_tc_nxt  = w_up.hit;
        w_set_ovf = w_up.hit;
      end else begin
        w_cnt_nxt = w_dn.cnt;
        w_tc_nxt  = w_dn.hit;
        w_set_udf = w_dn.hit;
      end
    end
  end

  // Output register stage; flag set takes precedence over flag_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_tc    <= w_tc_nxt;
      r_ovf   <= w_set_ovf | (r_ovf & ~flag_clr);
      r_udf   <= w_set_udf | (r_udf & ~flag_clr);
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;
  assign udf   = r_udf;

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed bench for up_down_counter_mod (WIDTH=8, STEP_W=4) with hand-computed expectations.
module tb_up_down_counter_mod;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, ld, clr, mode, sat, flag_clr;
  logic [3:0] step;
  logic [7:0] limit, d_in;
  logic [7:0] count;
  logic       tc, ovf, udf;

  int checks   = 0;
  int failures = 0;

  up_down_counter_mod #(.WIDTH(8), .STEP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .clr(clr), .mode(mode), .sat(sat),
    .step(step), .limit(limit), .d_in(d_in), .flag_clr(flag_clr),
    .count(count), .tc(tc), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] c, input logic t,
                         input logic o, input logic u);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".tc"},    32'(tc),    32'(t));
    chk({tag, ".ovf"},   32'(ovf),   32'(o));
    chk({tag, ".udf"},   32'(udf),   32'(u));
  endtask

  task automatic load(input logic [7:0] v, input logic [7:0] lim);
    en = 1'b0; clr = 1'b0; flag_clr = 1'b0;
    ld = 1'b1; d_in = v; limit = lim;
    tick();
    ld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ld = 1'b0; clr = 1'b0; mode = 1'b1; sat = 1'b0;
    flag_clr = 1'b0; step = 4'd1; limit = 8'd9; d_in = 8'd0;
    tick(); tick();
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // BCD wrap up: 1..9,0,1,2 with tc on 9 and on the wrap to 0
    limit = 8'd9; step = 4'd1; sat = 1'b0; mode = 1'b1; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("bcd.count", 32'(count), 32'((i + 1) % 10));
      chk("bcd.tc", 32'(tc), 32'((((i + 1) % 10) == 9) || (((i + 1) % 10) == 0)));
    end
    chk("bcd.ovf", 32'(ovf), 32'd1);
    en = 1'b0;
    tick();
    chk_all("hold", 8'd2, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges
    load(8'd37, 8'd255);
    chk("load37", 32'(count), 32'd37);
    #3 rst_n = 1'b0;
    #1 chk_all("async_rst", 8'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    tick();

    // Step-3 down wrap
    load(8'd1, 8'd9);
    step = 4'd3; mode = 1'b0; sat = 1'b0; en = 1'b1;
    tick();
    chk_all("dn_wrap", 8'd8, 1'b1, 1'b0, 1'b1);

    // Step-3 down saturate, then saturated hold pulses tc
    load(8'd1, 8'd9);
    step = 4'd3; mode = 1'b0; sat = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dn_sat.count", 32'(count), 32'd0);
      chk("dn_sat.tc", 32'(tc), 32'd1);
    end
    en = 1'b0;
    tick();
    chk("dn_sat.idle_tc", 32'(tc), 32'd0);

    // Up saturate at limit
    load(8'd8, 8'd9);
    mode = 1'b1; sat = 1'b1; step = 4'd3; en = 1'b1;
    tick();
    chk_all("up_sat1", 8'd9, 1'b1, 1'b1, 1'b1);
    tick();
    chk_all("up_sat2", 8'd9, 1'b1, 1'b1, 1'b1);
    en = 1'b0;

    // Priority ld > clr > en with clamp to limit; flags untouched
    ld = 1'b1; clr = 1'b1; en = 1'b1; d_in = 8'd200; limit = 8'd150; sat = 1'b0;
    tick();
    chk_all("prio_ld", 8'd150, 1'b0, 1'b1, 1'b1);
    ld = 1'b0;
    tick();
    chk_all("prio_clr", 8'd0, 1'b0, 1'b1, 1'b1);
    clr = 1'b0; en = 1'b0;

    // Flag clear with no event
    flag_clr = 1'b1;
    tick();
    chk_all("flag_clr", 8'd0, 1'b0, 1'b0, 1'b0);
    flag_clr = 1'b0;

    // Runtime limit reduction, up/wrap
    load(8'd50, 8'd200);
    limit = 8'd20; mode = 1'b1; sat = 1'b0; step = 4'd1; en = 1'b1;
    tick();
    chk_all("lim_up", 8'd0, 1'b1, 1'b1, 1'b0);
    en = 1'b0; flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;

    // Runtime limit reduction, down
    load(8'd50, 8'd200);
    limit = 8'd20; mode = 1'b0; en = 1'b1;
    tick();
    chk_all("lim_dn", 8'd20, 1'b1, 1'b0, 1'b1);

    // Set beats flag_clr on the same edge
    load(8'd8, 8'd9);
    mode = 1'b1; sat = 1'b0; step = 4'd3; en = 1'b1;
    tick();
    chk_all("up_wrap", 8'd1, 1'b1, 1'b1, 1'b1);
    step = 4'd9; flag_clr = 1'b1;
    tick();
    chk_all("set_wins", 8'd0, 1'b1, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    flag_clr = 1'b0;
    chk("flags_cleared", 32'(ovf), 32'd0);

    // Illegal step larger than limit holds
    load(8'd5, 8'd9);
    step = 4'd12; mode = 1'b1; en = 1'b1;
    tick();
    chk_all("ill_up", 8'd5, 1'b0, 1'b0, 1'b0);
    mode = 1'b0;
    tick();
    chk_all("ill_dn", 8'd5, 1'b0, 1'b0, 1'b0);
    step = 4'd0;
    tick();
    chk_all("step0", 8'd5, 1'b0, 1'b0, 1'b0);

    // limit=0 pins count to 0
    load(8'd7, 8'd0);
    chk("lim0_load", 32'(count), 32'd0);
    step = 4'd1; mode = 1'b1; en = 1'b1;
    tick();
    chk_all("lim0_step", 8'd0, 1'b0, 1'b0, 1'b0);
    en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
